// File: rtl/twi_pkg.sv
// Shared types and defaults for the TWI line conditioner.
// Bus state enum, default timing constants, saturating add helper.
package twi_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } twi_bus_state_t;

    localparam int TWI_SYNC_STAGES    = 2;
    localparam int TWI_FILT_CYCLES    = 3;
    localparam int TWI_TIMEOUT_CYCLES = 1250000;

    function automatic logic [7:0] twi_sat_add8(
        input logic [7:0] a,
        input logic [1:0] b
    );
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, b};
        return sum[8] ? 8'hff : sum[7:0];
    endfunction

endpackage

// File: rtl/twi_glitch_filter.sv
// Pad synchroniser plus persistence filter for one TWI line.
// reject pulses when a pending level change collapses before acceptance.
module twi_glitch_filter
    import twi_pkg::*;
#(
    parameter int SYNC_STAGES = TWI_SYNC_STAGES,
    parameter int FILT_CYCLES = TWI_FILT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    output logic f,
    output logic reject
);

    localparam int CW = $clog2(FILT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   f_q, f_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the pad in; count how long s has disagreed with f.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad};
        f_d    = f_q;
        cnt_d  = '0;
        reject = 1'b0;
        if (s != f_q) begin
            if (cnt_q == CW'(FILT_CYCLES - 1)) begin
                f_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            reject = (cnt_q != '0);
        end
    end

    // Idle bus is high, so everything resets to 1 except the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            f_q    <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            f_q    <= f_d;
            cnt_q  <= cnt_d;
        end
    end

    assign f = f_q;

endmodule

// File: rtl/twi_line_conditioner.sv
// TWI front end: filtered SDA/SCL, event strobes, busy tracking.
// Define TWI_LC_GLITCH_CNT_EN to add the glitch_count output.
module twi_line_conditioner
    import twi_pkg::*;
#(
    parameter int SYNC_STAGES    = TWI_SYNC_STAGES,
    parameter int FILT_CYCLES    = TWI_FILT_CYCLES,
    parameter int TIMEOUT_CYCLES = TWI_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       SDA,
    input  logic       SCL,
    output logic       sda_f,
    output logic       scl_f,
    output logic       scl_rise,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic       timeout_err
`ifdef TWI_LC_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_count
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic sda_rej, scl_rej;

    twi_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES)
    ) u_sda_filt (
        .clk    (clk),
        .reset  (reset),
        .pad    (SDA),
        .f      (sda_f),
        .reject (sda_rej)
    );

    twi_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES)
    ) u_scl_filt (
        .clk    (clk),
        .reset  (reset),
        .pad    (SCL),
        .f      (scl_f),
        .reject (scl_rej)
    );

    logic sda_q, sda_d;
    logic scl_q, scl_d;
    logic rise_ev, start_ev, stop_ev, to_ev;

    assign rise_ev  = !scl_q & scl_f;
    assign start_ev = sda_q & !sda_f & scl_q & scl_f;
    assign stop_ev  = !sda_q & sda_f & scl_q & scl_f;

    twi_bus_state_t state_q, state_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;

    // Bus state and SCL-low watchdog; independent of enable.
    always_comb begin
        state_d  = state_q;
        to_cnt_d = '0;
        to_ev    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ev) state_d = BUSY;
            end
            BUSY: begin
                if (stop_ev) begin
                    state_d = IDLE;
                end else if (!scl_f) begin
                    if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        to_ev   = 1'b1;
                        state_d = IDLE;
                    end else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold state and watchdog count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    logic scl_rise_q, scl_rise_d;
    logic start_q, start_d;
    logic stop_q, stop_d;
    logic to_q, to_d;
    logic busy_q, busy_d;

    // Strobes gated by enable; previous-level copies for edge detect.
    always_comb begin
        sda_d      = sda_f;
        scl_d      = scl_f;
        scl_rise_d = enable & rise_ev;
        start_d    = enable & start_ev;
        stop_d     = enable & stop_ev;
        to_d       = enable & to_ev;
        busy_d     = (state_q == BUSY);
    end

    // Register strobes and busy flag; idle-high previous levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sda_q      <= 1'b1;
            scl_q      <= 1'b1;
            scl_rise_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            to_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sda_q      <= sda_d;
            scl_q      <= scl_d;
            scl_rise_q <= scl_rise_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            to_q       <= to_d;
            busy_q     <= busy_d;
        end
    end

    assign scl_rise    = scl_rise_q;
    assign start_det   = start_q;
    assign stop_det    = stop_q;
    assign timeout_err = to_q;
    assign bus_busy    = busy_q;

`ifdef TWI_LC_GLITCH_CNT_EN
    logic [7:0] glitch_q, glitch_d;

    // Saturating count of rejected spikes on both lines.
    always_comb begin
        glitch_d = twi_sat_add8(glitch_q, {1'b0, sda_rej} + {1'b0, scl_rej});
    end

    // Hold the spike count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_q <= 8'h00;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_count = glitch_q;
`else
    logic unused_rej;
    assign unused_rej = sda_rej | scl_rej;
`endif

endmodule

// File: tb/tb_twi_line_conditioner.sv
// Directed and random stimulus against a cycle reference model.
// Optional glitch_count checks when TWI_LC_GLITCH_CNT_EN is defined.
module tb_twi_line_conditioner;

    localparam int SYNC = 2;
    localparam int FILT = 3;
    localparam int TOC  = 100;
    localparam int HP   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic sda_pad = 1'b0;
    logic scl_pad = 1'b0;
    logic sda_f, scl_f, scl_rise, start_det, stop_det, bus_busy, timeout_err;
`ifdef TWI_LC_GLITCH_CNT_EN
    logic [7:0] glitch_count;
`endif

    twi_line_conditioner #(
        .SYNC_STAGES    (SYNC),
        .FILT_CYCLES    (FILT),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .enable      (enable),
        .SDA         (sda_pad),
        .SCL         (scl_pad),
        .sda_f       (sda_f),
        .scl_f       (scl_f),
        .scl_rise    (scl_rise),
        .start_det   (start_det),
        .stop_det    (stop_det),
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err)
`ifdef TWI_LC_GLITCH_CNT_EN
        ,
        .glitch_count (glitch_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_rise = 0, n_start = 0, n_stop = 0, n_to = 0;

    // Reference model: line 0 = SDA, line 1 = SCL.
    bit sp   [2][SYNC];
    bit hist [2][FILT];
    bit mf [2];
    bit mq [2];
    bit m_busy;
    int lowrun;
    int m_gc;
    bit e_rise, e_start, e_stop, e_to, e_busy;

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < SYNC; k++) sp[l][k] = 1'b1;
            for (int k = 0; k < FILT; k++) hist[l][k] = 1'b1;
            mf[l] = 1'b1;
            mq[l] = 1'b1;
        end
        m_busy = 0; lowrun = 0; m_gc = 0;
        e_rise = 0; e_start = 0; e_stop = 0; e_to = 0; e_busy = 0;
    endtask

    task automatic model_line(input int l, input bit p, output bit fnew, output bit rej);
        bit s, last, all;
        s = sp[l][SYNC-1];
        for (int k = SYNC-1; k > 0; k--) sp[l][k] = sp[l][k-1];
        sp[l][0] = p;
        last = hist[l][FILT-1];
        for (int k = 0; k < FILT-1; k++) hist[l][k] = hist[l][k+1];
        hist[l][FILT-1] = s;
        all = 1'b1;
        for (int k = 0; k < FILT; k++) all &= (hist[l][k] != mf[l]);
        rej  = (s == mf[l]) && (last != mf[l]);
        fnew = all ? s : mf[l];
    endtask

    task automatic model_step();
        bit st, sp_ev, ri, to, fs, fc, rs, rc;
        if (rst) begin
            model_reset();
            return;
        end
        st    = mq[0] & !mf[0] & mq[1] & mf[1];
        sp_ev = !mq[0] & mf[0] & mq[1] & mf[1];
        ri    = !mq[1] & mf[1];
        to    = 0;
        e_busy = m_busy;
        if (m_busy) begin
            if (sp_ev) begin
                m_busy = 0; lowrun = 0;
            end else if (!mf[1]) begin
                lowrun++;
                if (lowrun == TOC) begin
                    to = 1; m_busy = 0; lowrun = 0;
                end
            end else begin
                lowrun = 0;
            end
        end else begin
            lowrun = 0;
            if (st) m_busy = 1;
        end
        e_rise  = enable & ri;
        e_start = enable & st;
        e_stop  = enable & sp_ev;
        e_to    = enable & to;
        model_line(0, sda_pad, fs, rs);
        model_line(1, scl_pad, fc, rc);
        m_gc = m_gc + int'(rs) + int'(rc);
        if (m_gc > 255) m_gc = 255;
        mq[0] = mf[0]; mf[0] = fs;
        mq[1] = mf[1]; mf[1] = fc;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("sda_f", 32'(sda_f), 32'(mf[0]));
        chk("scl_f", 32'(scl_f), 32'(mf[1]));
        chk("scl_rise", 32'(scl_rise), 32'(e_rise));
        chk("start_det", 32'(start_det), 32'(e_start));
        chk("stop_det", 32'(stop_det), 32'(e_stop));
        chk("timeout_err", 32'(timeout_err), 32'(e_to));
        chk("bus_busy", 32'(bus_busy), 32'(e_busy));
`ifdef TWI_LC_GLITCH_CNT_EN
        chk("glitch_count", 32'(glitch_count), 32'(m_gc));
`endif
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
            n_rise  += int'(scl_rise === 1'b1);
            n_start += int'(start_det === 1'b1);
            n_stop  += int'(stop_det === 1'b1);
            n_to    += int'(timeout_err === 1'b1);
        end
    endtask

    task automatic bus_start();
        sda_pad = 1; scl_pad = 1; tick(HP);
        sda_pad = 0; tick(HP);
        scl_pad = 0; tick(HP);
    endtask

    task automatic send_bit(input bit b);
        sda_pad = b; tick(HP);
        scl_pad = 1; tick(HP);
        scl_pad = 0; tick(HP);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(ack);
    endtask

    task automatic bus_stop();
        sda_pad = 0; tick(HP);
        scl_pad = 1; tick(HP);
        sda_pad = 1; tick(HP);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, r0, s0, p0, t0;
`ifdef TWI_LC_GLITCH_CNT_EN
        int g0;
`endif
        model_reset();
        @(negedge clk);
        tick(4);
        chk("rst_sda_f", 32'(sda_f), 32'd1);
        chk("rst_scl_f", 32'(scl_f), 32'd1);
        chk("rst_busy", 32'(bus_busy), 32'd0);

        rst = 0;
        s0 = n_start;
        n = 0;
        do begin tick(1); n++; end while (scl_f !== 1'b0 && n < 20);
        chk("release_latency", n, 5);
        sda_pad = 1; scl_pad = 1; tick(12);
        chk("release_no_start", n_start - s0, 0);

        sda_pad = 0;
        n = 0;
        do begin tick(1); n++; end while (start_det !== 1'b1 && n < 20);
        chk("start_latency", n, 6);
        tick(1);
        chk("start_single", 32'(start_det), 32'd0);
        chk("busy_after_start", 32'(bus_busy), 32'd1);

        r0 = n_rise;
`ifdef TWI_LC_GLITCH_CNT_EN
        g0 = int'(glitch_count);
`endif
        scl_pad = 0; tick(2);
        scl_pad = 1; tick(12);
        chk("spike_no_rise", n_rise - r0, 0);
`ifdef TWI_LC_GLITCH_CNT_EN
        chk("spike_glitch_inc", int'(glitch_count) - g0, 1);
`endif

        p0 = n_stop;
        sda_pad = 1; tick(12);
        chk("stop_pulse", n_stop - p0, 1);
        chk("busy_after_stop", 32'(bus_busy), 32'd0);

        sda_pad = 0; tick(12);
        chk("busy_before_to", 32'(bus_busy), 32'd1);
        scl_pad = 0;
        n = 0;
        do begin tick(1); n++; end while (scl_f !== 1'b0 && n < 20);
        n = 0;
        do begin tick(1); n++; end while (timeout_err !== 1'b1 && n < 150);
        chk("timeout_latency", n, TOC);
        tick(1);
        chk("busy_after_to", 32'(bus_busy), 32'd0);
        t0 = n_to;
        tick(250);
        chk("timeout_once", n_to - t0, 0);
        scl_pad = 1; tick(12);
        p0 = n_stop;
        sda_pad = 1; tick(12);
        chk("stop_in_idle", n_stop - p0, 1);
        chk("idle_stays", 32'(bus_busy), 32'd0);

        enable = 0;
        r0 = n_rise; s0 = n_start; p0 = n_stop;
        bus_start();
        chk("dis_busy_tracks", 32'(bus_busy), 32'd1);
        send_byte(8'hA5, 1'b0);
        bus_stop();
        tick(10);
        chk("dis_no_rise", n_rise - r0, 0);
        chk("dis_no_start", n_start - s0, 0);
        chk("dis_no_stop", n_stop - p0, 0);
        chk("dis_busy_end", 32'(bus_busy), 32'd0);

        enable = 1;
        s0 = n_start; p0 = n_stop;
        bus_start();
        r0 = n_rise;
        send_byte(8'h3C, 1'b1);
        chk("frame_rises", n_rise - r0, 9);
        bus_stop();
        tick(10);
        chk("frame_start", n_start - s0, 1);
        chk("frame_stop", n_stop - p0, 1);

        s0 = n_start; p0 = n_stop;
        sda_pad = 0; scl_pad = 0; tick(12);
        chk("simul_fall_no_start", n_start - s0, 0);
        chk("simul_fall_idle", 32'(bus_busy), 32'd0);
        sda_pad = 1; scl_pad = 1; tick(12);
        chk("simul_rise_no_stop", n_stop - p0, 0);

        bus_start();
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        s0 = n_start;
        sda_pad = 1; tick(HP);
        scl_pad = 1; tick(HP);
        sda_pad = 0; tick(HP);
        scl_pad = 0; tick(HP);
        chk("rep_start_pulse", n_start - s0, 1);
        chk("rep_start_busy", 32'(bus_busy), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        bus_stop();
        tick(10);

        for (int i = 0; i < 400; i++) begin
            enable  = ($urandom_range(0, 3) != 0);
            sda_pad = 1'($urandom_range(0, 1));
            scl_pad = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 5));
        end

        enable = 1;
        sda_pad = 1; scl_pad = 1; tick(12);
        sda_pad = 0; tick(12);
        chk("pre_reset_busy", 32'(bus_busy), 32'd1);
        rst = 1;
        #1;
        chk("async_reset_busy", 32'(bus_busy), 32'd0);
        tick(2);
        chk("reset_sda_f", 32'(sda_f), 32'd1);
        sda_pad = 1;
        rst = 0;
        r0 = n_rise; s0 = n_start; p0 = n_stop; t0 = n_to;
        tick(20);
        chk("release_quiet", (n_rise - r0) + (n_start - s0) + (n_stop - p0) + (n_to - t0), 0);
        chk("release_idle", 32'(bus_busy), 32'd0);
        sda_pad = 0; tick(12);
        chk("restart_busy", 32'(bus_busy), 32'd1);
        bus_stop();
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
